// File: rtl/display_timing_gen.sv
// Parametrised raster timing generator with pixel clock-enable.
// Registered outputs decode the next-position counters, so every output describes the same pixel.
module display_timing_gen #(
    parameter int   CORDW  = 10,
    parameter int   H_RES  = 640,
    parameter int   H_FP   = 16,
    parameter int   H_SYNC = 96,
    parameter int   H_BP   = 48,
    parameter int   V_RES  = 480,
    parameter int   V_FP   = 10,
    parameter int   V_SYNC = 2,
    parameter int   V_BP   = 33,
    parameter logic H_POL  = 1'b0,
    parameter logic V_POL  = 1'b0
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    input  logic             ce,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line,
    output logic             frame
);
    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_RES);
    localparam logic [CORDW-1:0] HS_STA = CORDW'(H_RES + H_FP);
    localparam logic [CORDW-1:0] HS_END = CORDW'(H_RES + H_FP + H_SYNC);
    localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_RES);
    localparam logic [CORDW-1:0] VS_STA = CORDW'(V_RES + V_FP);
    localparam logic [CORDW-1:0] VS_END = CORDW'(V_RES + V_FP + V_SYNC);
    localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);

    logic [CORDW-1:0] r_nx, r_ny;
    logic [CORDW-1:0] r_sx, r_sy;
    logic             r_hsync, r_vsync, r_de, r_line, r_frame;

    logic [CORDW-1:0] w_nx_next, w_ny_next;
    logic             w_hs_act, w_vs_act, w_de;

    always_comb begin
        w_nx_next = r_nx + CORDW'(1);
        w_ny_next = r_ny;
        if (r_nx == H_LAST) begin
            w_nx_next = '0;
            w_ny_next = (r_ny == V_LAST) ? '0 : r_ny + CORDW'(1);
        end
    end

    always_comb begin
        w_hs_act = (r_nx >= HS_STA) && (r_nx < HS_END);
        w_vs_act = (r_ny >= VS_STA) && (r_ny < VS_END);
        w_de     = (r_nx < H_ACT) && (r_ny < V_ACT);
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_nx    <= '0;
            r_ny    <= '0;
            r_sx    <= '0;
            r_sy    <= '0;
            r_hsync <= ~H_POL;
            r_vsync <= ~V_POL;
            r_de    <= 1'b0;
            r_line  <= 1'b0;
            r_frame <= 1'b0;
        end else if (ce) begin
            r_sx    <= r_nx;
            r_sy    <= r_ny;
            r_hsync <= w_hs_act ? H_POL : ~H_POL;
            r_vsync <= w_vs_act ? V_POL : ~V_POL;
            r_de    <= w_de;
            r_line  <= (r_nx == '0);
            r_frame <= (r_nx == '0) && (r_ny == '0);
            r_nx    <= w_nx_next;
            r_ny    <= w_ny_next;
        end else begin
            // strobes drop on idle cycles so they stay one clk_pix wide at any ce duty
            r_line  <= 1'b0;
            r_frame <= 1'b0;
        end
    end

    assign sx    = r_sx;
    assign sy    = r_sy;
    assign hsync = r_hsync;
    assign vsync = r_vsync;
    assign de    = r_de;
    assign line  = r_line;
    assign frame = r_frame;
endmodule

// File: doc/display_timing_gen.md
Name: display_timing_gen

Overview:
- Parametrised successor to the fixed 640x480p60 timing generator.
- Produces the raster position, sync signals, data enable, and line/frame start strobes for any CEA/VESA-style mode.
- Resolution, porches, sync widths, sync polarity and coordinate width are set by parameters.
- A pixel clock-enable lets the block run from a faster system clock. It sits between the pixel clock domain and the pixel generators / video encoder.

Parameters:
- CORDW, 10, coordinate width in bits; must satisfy 2^CORDW > max(H_TOTAL, V_TOTAL)-1.
- H_RES, 640, active pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_RES, 480, active lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines).
- H_POL, 0, hsync active level (0 = negative polarity).
- V_POL, 0, vsync active level (0 = negative polarity).

Ports:
- clk_pix  input  1  pixel/system clock
- rst_pix_n  input  1  asynchronous active-low reset
- ce  input  1  pixel enable; one raster position advances per clk_pix cycle with ce=1
- sx  output  CORDW  horizontal position of current output pixel
- sy  output  CORDW  vertical position of current output pixel
- hsync  output  1  horizontal sync, level per H_POL
- vsync  output  1  vertical sync, level per V_POL
- de  output  1  data enable, high in active area
- line  output  1  one-cycle strobe at start of each line (sx=0)
- frame  output  1  one-cycle strobe at start of each frame (sx=0, sy=0)

Behaviour:
- Derived timing values:
  - H_TOTAL = H_RES+H_FP+H_SYNC+H_BP (default 800).
  - V_TOTAL = V_RES+V_FP+V_SYNC+V_BP (default 525).
  - Horizontal sync active for H_RES+H_FP <= x < H_RES+H_FP+H_SYNC (default 656..751).
  - Vertical sync active for V_RES+V_FP <= y < V_RES+V_FP+V_SYNC (default 490..491).
  - de = (x < H_RES) && (y < V_RES).
- Internal next-position counters nx, ny (CORDW bits). All outputs are registered; no combinational path from inputs to outputs.
- On a clk_pix edge with ce=1:
  - Outputs load the decode of (nx, ny): sx<=nx, sy<=ny; hsync/vsync/de per the rules above.
  - line <= (nx==0); frame <= (nx==0 && ny==0).
  - nx advances; at nx==H_TOTAL-1 it wraps to 0 and ny advances; at ny==V_TOTAL-1 with the line wrap, ny wraps to 0.
- Latency: one clk_pix cycle from the ce cycle to the outputs. sx, sy, hsync, vsync, de, line and frame are always mutually consistent for the same pixel.
- On a clk_pix edge with ce=0:
  - sx, sy, hsync, vsync, de and the counters hold.
  - line and frame are forced to 0, so the strobes are exactly one clk_pix cycle wide regardless of ce duty.
- Reset (rst_pix_n=0, asynchronous assert, synchronous-safe deassert expected from the system):
  - nx=0, ny=0, sx=0, sy=0, de=0, line=0, frame=0.
  - hsync=~H_POL, vsync=~V_POL (inactive).
  - Reset mid-frame takes effect immediately without a clock edge.
- First ce after reset release outputs (0,0) with de=1, line=1, frame=1.
- Counter arithmetic is unsigned CORDW; comparisons are against localparam constants. No overflow is possible given the CORDW constraint.
- ce is sampled every clk_pix cycle. A permanently high ce yields one pixel per clock, equivalent to the fixed generator with registered outputs.

Test Plan:
- Defaults, reset then ce=1 continuously:
  - First output cycle shows sx=0, sy=0, de=1, line=1, frame=1.
  - Next cycle shows sx=1, line=0, frame=0.
  - hsync=0 for exactly sx 656..751 (96 cycles), 1 elsewhere.
- Defaults, ce=1:
  - Line wrap sx 799 -> 0 with sy+1 and line=1.
  - Frame wrap at (799,524) -> (0,0) with frame=1.
  - frame strobes exactly 420000 cycles apart; vsync=0 only for sy 490..491; de=0 for all sy>=480.
- ce high 1 cycle in 4:
  - Outputs change only after ce cycles.
  - line and frame are 1 clk_pix wide; frame period is 1,680,000 clocks.
- Assert rst_pix_n=0 mid-line at sx=300, sy=100 between clock edges:
  - Outputs go to reset values immediately.
  - After release, the first ce gives (0,0) with frame=1.
- Small mode H_RES=4, H_FP=1, H_SYNC=2, H_BP=1, V_RES=2, V_FP=1, V_SYNC=1, V_BP=1, H_POL=1, V_POL=1, CORDW=4:
  - 8x5 raster.
  - hsync=1 only at sx 5..6; vsync=1 only at sy 3.
  - de only for sx<4, sy<2; frame every 40 ce cycles.
